// File: rtl/hc_sr04_echo_responder.sv
// HC-SR04 ultrasonic sensor emulator: validates a trigger pulse, waits out the burst
// delay, then returns an echo pulse whose width encodes a programmed distance in mm.
module hc_sr04_echo_responder #(
  parameter int MIN_TRIG  = 500,
  parameter int BURST_DLY = 10000,
  parameter int TIMEOUT   = 1900000,
  parameter int MAX_MM    = 4000,
  parameter int HOLDOFF   = 500
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        trig_in,
  input  logic [15:0] distance_mm,
  input  logic        obj_present,
  output logic        echo_tx,
  output logic        busy,
  output logic        trig_err
);

  localparam int CW     = 21;
  localparam int DW     = 29;
  localparam int SYNC_N = 2;

  localparam logic [CW-1:0] MIN_TRIG_C   = CW'(MIN_TRIG);
  localparam logic [CW-1:0] BURST_LAST_C = CW'(BURST_DLY - 1);
  localparam logic [CW-1:0] HOLD_LAST_C  = CW'(HOLDOFF);
  localparam logic [CW-1:0] TIMEOUT_C    = CW'(TIMEOUT);
  localparam logic [31:0]   MAX_MM_C     = 32'(MAX_MM);
  localparam logic [5:0]    DIVISOR_C    = 6'd17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG_HI,
    ST_BURST,
    ST_ECHO,
    ST_HOLDOFF
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [SYNC_N-1:0] sync_reg;
  logic              trig_d_reg;
  logic              trig_s, trig_rise, trig_fall;
  logic              latch_en;
  logic              err_next, err_pend_reg, err_reg;
  logic              echo_reg, busy_reg;

  logic [15:0]       dist_reg;
  logic              obj_reg;

  logic [DW-1:0]     dvd_reg, dvd_load;
  logic [4:0]        rem_reg, rem_step;
  logic [CW-1:0]     quot_reg;
  logic [4:0]        div_cnt_reg;
  logic              div_run_reg;
  logic [5:0]        trial;
  logic              qbit;

  logic              use_timeout;
  logic [CW-1:0]     echo_w;

  // Input synchronizer plus one registered copy for edge detection.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      sync_reg   <= '0;
      trig_d_reg <= 1'b0;
    end else begin
      sync_reg   <= {sync_reg[SYNC_N-2:0], trig_in};
      trig_d_reg <= trig_s;
    end
  end

  assign trig_s    = sync_reg[SYNC_N-1];
  assign trig_rise = trig_s & ~trig_d_reg;
  assign trig_fall = ~trig_s & trig_d_reg;

  // Echo width in clocks: ceil(d*5000/17), clamped to at least one cycle.
  assign use_timeout = !obj_reg || ({16'd0, dist_reg} > MAX_MM_C);
  assign echo_w      = use_timeout ? TIMEOUT_C :
                       ((quot_reg == '0) ? CW'(1) : quot_reg);

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch_en   = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        // The detect cycle already has trig_s high, so it is counted.
        if (trig_rise) begin
          state_next = ST_TRIG_HI;
          cnt_next   = CW'(1);
        end
      end
      ST_TRIG_HI: begin
        if (trig_fall) begin
          cnt_next = '0;
          if (cnt_reg >= MIN_TRIG_C) begin
            state_next = ST_BURST;
            latch_en   = 1'b1;
          end else begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
          end
        end else if (trig_s && (cnt_reg < MIN_TRIG_C)) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_BURST: begin
        if (cnt_reg == BURST_LAST_C) begin
          state_next = ST_ECHO;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_ECHO: begin
        if (cnt_reg == (echo_w - CW'(1))) begin
          state_next = ST_HOLDOFF;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_HOLDOFF: begin
        if (cnt_reg == HOLD_LAST_C) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      dist_reg <= '0;
      obj_reg  <= 1'b0;
    end else if (latch_en) begin
      dist_reg <= distance_mm;
      obj_reg  <= obj_present;
    end
  end

  // Restoring divide by 17, one quotient bit per clock; finishes well inside BURST.
  assign dvd_load = {13'd0, distance_mm} * DW'(5000) + DW'(16);
  assign trial    = {rem_reg, dvd_reg[DW-1]};
  assign qbit     = (trial >= DIVISOR_C);
  assign rem_step = qbit ? 5'(trial - DIVISOR_C) : trial[4:0];

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      dvd_reg     <= '0;
      rem_reg     <= '0;
      quot_reg    <= '0;
      div_cnt_reg <= '0;
      div_run_reg <= 1'b0;
    end else if (latch_en) begin
      dvd_reg     <= dvd_load;
      rem_reg     <= '0;
      quot_reg    <= '0;
      div_cnt_reg <= '0;
      div_run_reg <= 1'b1;
    end else if (div_run_reg) begin
      dvd_reg     <= {dvd_reg[DW-2:0], 1'b0};
      rem_reg     <= rem_step;
      quot_reg    <= {quot_reg[CW-2:0], qbit};
      div_cnt_reg <= div_cnt_reg + 5'd1;
      if (div_cnt_reg == 5'(DW - 1)) begin
        div_run_reg <= 1'b0;
      end
    end
  end

  // Outputs come straight from flops, decoded from the next state.
  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      echo_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      err_pend_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      echo_reg     <= (state_next == ST_ECHO);
      busy_reg     <= (state_next != ST_IDLE);
      err_pend_reg <= err_next;
      err_reg      <= err_pend_reg;
    end
  end

  assign echo_tx  = echo_reg;
  assign busy     = busy_reg;
  assign trig_err = err_reg;

endmodule

// File: tb/tb_hc_sr04_echo_responder.sv
// Bench for hc_sr04_echo_responder: a window-based timing model checked every cycle,
// plus literal echo widths and latencies for each directed measurement.
module tb_hc_sr04_echo_responder;

  localparam int MIN_TRIG  = 20;
  localparam int BURST_DLY = 40;
  localparam int TIMEOUT   = 2500;
  localparam int MAX_MM    = 69;
  localparam int HOLDOFF   = 60;

  logic        clk_50M = 1'b0;
  logic        reset = 1'b0;
  logic        trig_in = 1'b0;
  logic [15:0] distance_mm = 16'd0;
  logic        obj_present = 1'b0;
  logic        echo_tx, busy, trig_err;

  hc_sr04_echo_responder #(
    .MIN_TRIG(MIN_TRIG), .BURST_DLY(BURST_DLY), .TIMEOUT(TIMEOUT),
    .MAX_MM(MAX_MM), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk_50M(clk_50M), .reset(reset), .trig_in(trig_in),
    .distance_mm(distance_mm), .obj_present(obj_present),
    .echo_tx(echo_tx), .busy(busy), .trig_err(trig_err)
  );

  always #10 clk_50M = ~clk_50M;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Expected windows in absolute cycle numbers, [start, end).
  int m_echo_s = 0, m_echo_e = 0, m_busy_s = 0, m_busy_e = 0, m_err = -1, m_e0 = 0;

  int   rise_cyc = 0, last_width = 0, echo_count = 0, err_cycles = 0;
  logic prev_echo = 1'b0;

  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int exp_width(input int d, input bit obj);
    int w;
    if (!obj || d > MAX_MM) return TIMEOUT;
    w = (d * 5000 + 16) / 17;
    return (w < 1) ? 1 : w;
  endfunction

  always @(negedge clk_50M) begin
    if (chk_en) begin
      check("echo_tx", 32'(echo_tx), 32'(cyc >= m_echo_s && cyc < m_echo_e));
      check("busy", 32'(busy), 32'(cyc >= m_busy_s && cyc < m_busy_e));
      check("trig_err", 32'(trig_err), 32'(cyc == m_err));
      if (echo_tx === 1'b1 && prev_echo === 1'b0) begin
        rise_cyc = cyc;
        echo_count++;
      end
      if (echo_tx === 1'b0 && prev_echo === 1'b1) last_width = cyc - rise_cyc;
      if (trig_err === 1'b1) err_cycles++;
      prev_echo = echo_tx;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic tick_until(input int c);
    while (cyc < c) tick(1);
  endtask

  // One trigger of n cycles; the model windows are set from the spec's timing rules.
  task automatic meas(input int n, input int d, input bit obj);
    int r0, w;
    distance_mm = 16'(d);
    obj_present = obj;
    r0   = cyc + 1;
    m_e0 = r0 + n;
    if (n >= MIN_TRIG) begin
      w        = exp_width(d, obj);
      m_echo_s = m_e0 + 2 + BURST_DLY;
      m_echo_e = m_echo_s + w;
      m_busy_s = r0 + 2;
      m_busy_e = m_echo_e + HOLDOFF + 1;
      m_err    = -1;
    end else begin
      w        = 0;
      m_echo_s = 0;
      m_echo_e = 0;
      m_busy_s = r0 + 2;
      m_busy_e = m_e0 + 2;
      m_err    = m_e0 + 3;
    end
    trig_in = 1'b1;
    tick(n);
    trig_in = 1'b0;
    tick(4);
    distance_mm = 16'($urandom);
    obj_present = 1'($urandom_range(0, 1));
    $display("meas: trig=%0d d=%0d obj=%0d expected_width=%0d", n, d, obj, w);
  endtask

  task automatic ignored_trig(input int n);
    trig_in = 1'b1;
    tick(n);
    trig_in = 1'b0;
    tick(2);
    $display("busy trigger: trig=%0d at cycle %0d", n, cyc);
  endtask

  task automatic finish_meas();
    tick_until(m_busy_e + 3);
  endtask

  task automatic check_echo(input string name, input int w, input int d);
    check({name, "_width"}, 32'(last_width), 32'(w));
    check({name, "_latency"}, 32'(rise_cyc - m_e0), 32'(2 + BURST_DLY));
    if (d >= 0) begin
      check({name, "_recv"}, 32'((last_width * 17) / 5000), 32'(d));
      check({name, "_recv_p1"}, 32'(((last_width + 1) * 17) / 5000), 32'(d));
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, cnt0, err0;
    reset = 1'b0;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    check("reset_echo", 32'(echo_tx), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err", 32'(trig_err), 32'd0);
    reset = 1'b1;
    tick(5);

    check("model_w69", 32'(exp_width(69, 1'b1)), 32'd20295);
    check("model_w0", 32'(exp_width(0, 1'b1)), 32'd1);
    check("model_w70", 32'(exp_width(70, 1'b1)), 32'd2500);
    check("model_w17", 32'(exp_width(17, 1'b1)), 32'd5000);

    meas(20, 69, 1'b1); finish_meas(); check_echo("nominal", 20295, 69);
    meas(20, 0, 1'b1);  finish_meas(); check_echo("zero", 1, 0);
    meas(25, 70, 1'b1); finish_meas(); check_echo("over_max", 2500, -1);
    meas(20, 5, 1'b0);  finish_meas(); check_echo("no_obj", 2500, -1);
    meas(20, 1, 1'b1);  finish_meas(); check_echo("one_mm", 295, 1);
    check("err_none", 32'(err_cycles), 32'd0);

    meas(19, 10, 1'b1); finish_meas();
    check("short19_err", 32'(err_cycles), 32'd1);
    meas(1, 10, 1'b1);  finish_meas();
    check("short1_err", 32'(err_cycles), 32'd2);
    check("short_no_echo", 32'(echo_count), 32'd5);

    cnt0 = echo_count;
    err0 = err_cycles;
    meas(20, 3, 1'b1);
    tick_until(m_echo_s + 5);
    ignored_trig(20);
    tick_until(m_echo_e + 3);
    ignored_trig(20);
    finish_meas();
    check_echo("busy_trig", 883, 3);
    check("busy_trig_echoes", 32'(echo_count - cnt0), 32'd1);
    check("busy_trig_err", 32'(err_cycles - err0), 32'd0);
    meas(20, 17, 1'b1); finish_meas(); check_echo("after_busy", 5000, 17);

    meas(20, 1, 1'b1);
    tick_until(m_echo_s + 147);
    reset = 1'b0;
    k = cyc + 1;
    if (m_echo_e > k) m_echo_e = k;
    if (m_busy_e > k) m_busy_e = k;
    tick(1);
    check("mid_reset_echo", 32'(echo_tx), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    $display("reset: asserted for one cycle at cycle %0d", k);
    tick(5);
    meas(20, 2, 1'b1); finish_meas(); check_echo("post_reset", 589, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hc_sr04_echo_responder.md
# hc_sr04_echo_responder

Synthesizable HC-SR04 sensor emulator, the responder end of the ultrasonic trigger/echo interface. It watches a trigger line, validates the pulse width, models the ultrasonic burst delay, then drives an echo pulse whose width encodes a programmed distance in mm. It is used for hardware-in-loop and bench checks of the ultrasonic measurement front end on the MazeSolver Bot FPGA, with no physical sensor attached.

## Interface
Parameters:
- MIN_TRIG, 500: minimum valid trigger high time in clk_50M cycles (10 us).
- BURST_DLY, 10000: cycles from accepted trigger fall to echo rise (200 us, models the 8-cycle 40 kHz burst). Must be ≥ 32.
- TIMEOUT, 1900000: echo width in cycles when there is no object (38 ms).
- MAX_MM, 4000: largest reportable distance. Above this, the block returns a TIMEOUT echo.
- HOLDOFF, 500: dead cycles after echo fall before a new trigger is accepted.

Ports:
- clk_50M, input, 1: 50 MHz clock.
- reset, input, 1: synchronous, active-low reset.
- trig_in, input, 1: trigger from the measuring block. Asynchronous to the block.
- distance_mm, input, 16: emulated object distance. Sampled once per measurement.
- obj_present, input, 1: 1 means an object is present. Sampled with distance_mm.
- echo_tx, output, 1: echo pulse to the measuring block.
- busy, output, 1: high in every state except IDLE.
- trig_err, output, 1: one-cycle pulse when a trigger is rejected for being too short.

## Operation
- trig_in passes through a 2-flop synchronizer to give trig_s. All edge detection uses trig_s and its registered copy.
- States:
  - IDLE: clear the trigger counter. On a trig_s rising edge, go to TRIG_HI. A trig_s level that is already high on entry to IDLE, with no rising edge, is ignored.
  - TRIG_HI: count cycles while trig_s is high. On the trig_s fall:
    - If count ≥ MIN_TRIG: latch distance_mm and obj_present, start the divider, go to BURST.
    - Otherwise: pulse trig_err for one cycle and return to IDLE.
  - BURST: count BURST_DLY cycles while the divider runs, then go to ECHO with echo_tx = 1.
  - ECHO: hold echo_tx high for W cycles, then drop it and go to HOLDOFF.
  - HOLDOFF: count HOLDOFF cycles, then return to IDLE.
- Echo width W:
  - If the latched obj_present = 0, or the latched distance > MAX_MM: W = TIMEOUT.
  - Otherwise: W = max(1, ceil(d·5000/17)), computed as (d·5000 + 16)/17.
  - The ceiling guarantees floor(W·17/5000) = d, and also floor((W+1)·17/5000) = d. A receiver that converts the echo width back to mm therefore recovers d exactly, even if it miscounts by one cycle.
- Divider:
  - Dividend is 29 bits wide. The largest value is 65535·5000+16 = 327,675,016 < 2^29.
  - Divisor is the constant 17. Use a sequential restoring divider, one quotient bit per cycle, 29 cycles.
  - The result is ready before BURST ends, which is why BURST_DLY ≥ 32.
  - The quotient register and the echo counter are 21 bits wide (TIMEOUT < 2^21).
- While busy, any trigger edge is ignored. It does not raise trig_err.
- distance_mm and obj_present changing after the latch point have no effect on the measurement in progress.

## Timing
- Reset values: echo_tx = 0, busy = 0, trig_err = 0, state IDLE. All counters, the divider and the synchronizer are cleared.
- Reset takes effect on the next clock edge, even mid-echo. echo_tx is 0 in the cycle after reset is sampled low.
- Trigger measurement: if trig_in is high for N cycles, the TRIG_HI count equals N ±1 because of synchronizer sampling. Bench margins allow for this.
- Latency: echo_tx rises exactly 2 + BURST_DLY cycles after the first clock edge that samples trig_in low, counted from that edge.
- Echo width: echo_tx stays high for exactly W consecutive cycles.
- trig_err asserts 3 cycles after the short trigger's trig_in fall is first sampled and lasts one cycle.
- Turnaround: busy deasserts HOLDOFF + 1 cycles after echo_tx falls. The earliest accepted next trigger edge comes after that point.
- busy asserts in the cycle after the trig_s rising edge is detected. It stays high through TRIG_HI, BURST, ECHO and HOLDOFF, and deasserts on entry to IDLE.

## Test plan
- Nominal measurement: trig_in high 500 cycles, distance_mm = 69, obj_present = 1 -> echo_tx rises 10002 cycles after trig_in falls and stays high 20295 cycles. A t1b_ultrasonic instance driven by this block reads distance 69 and op = 1.
- Zero and maximum distance: distance_mm = 0 -> W = 1. distance_mm = 4000 -> W = 1176471. distance_mm = 4001 -> W = 1900000.
- No object: obj_present = 0 with any distance_mm -> echo_tx high for 1900000 cycles, trig_err stays 0.
- Short trigger: trig_in high 300 cycles -> no echo_tx, trig_err high exactly one cycle, busy returns to 0.
- Trigger while busy: a second 500-cycle trigger during ECHO, and again during HOLDOFF -> ignored, first echo width unchanged, no trig_err. A trigger after busy falls is accepted normally.
- Reset mid-operation: reset low for 1 cycle halfway through ECHO -> echo_tx = 0 and busy = 0 next cycle. After reset releases, a new valid trigger produces a correct echo.
